// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    // Nine's complement of one BCD digit; wraps modulo 16 for non-BCD input.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return bcd_digit_t'(BCD_NINE - d);
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_stage.sv
// Single-digit combinational BCD add with decimal correction.
// In subtract mode the B digit is nine's-complemented before the add.
module bcd_digit_stage
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t bd;
    logic [4:0] t;

    // Binary add of the two digits plus carry, then +6 correction above 9.
    always_comb begin
        bd = sub ? nines_comp(b) : b;
        t  = {1'b0, a} + {1'b0, bd} + {4'b0000, cin};
        if (t > 5'd9) begin
            digit = bcd_digit_t'(t[3:0] + BCD_CORR);
            cout  = 1'b1;
        end else begin
            digit = t[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first, one digit per
// clock through a single shared digit stage, start/done handshake.
// Optional build macro: BCD_CHECK_EN enables the non-BCD input digit check;
// without it the invalid output is tied low.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [W-1:0]     sum_reg;
    logic             cout_reg;

    // Bit offset of the digit currently being processed.
    logic [IDX_W+1:0] lsb;
    assign lsb = {idx_reg, 2'b00};

    bcd_digit_t a_dig;
    bcd_digit_t b_dig;
    bcd_digit_t stage_digit;
    logic       stage_cout;

    assign a_dig = a_reg[lsb +: 4];
    assign b_dig = b_reg[lsb +: 4];

    bcd_digit_stage u_stage (
        .a     (a_dig),
        .b     (b_dig),
        .cin   (carry_reg),
        .sub   (sub_reg),
        .digit (stage_digit),
        .cout  (stage_cout)
    );

    // Control FSM, operand capture and digit-by-digit result insertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        // Subtract adds the ten's complement: nine's
                        // complement plus one, less any incoming borrow.
                        carry_reg <= cin ^ sub;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[lsb +: 4] <= stage_digit;
                    carry_reg         <= stage_cout;
                    idx_reg           <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= stage_cout;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef BCD_CHECK_EN
    logic [2*DIGITS-1:0] nib_bad;
    logic                invalid_reg;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
            assign nib_bad[gi]          = (a[4*gi +: 4] > BCD_NINE);
            assign nib_bad[DIGITS + gi] = (b[4*gi +: 4] > BCD_NINE);
        end
    endgenerate

    // Flag any non-BCD operand nibble at acceptance; held until next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            invalid_reg <= |nib_bad;
        end
    end

    assign invalid = invalid_reg;
`else
    assign invalid = 1'b0;
`endif

endmodule
